// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   rf_state_e - clear-sweep FSM states (RF_INIT while clearing, RF_READY after)
//   XLEN_DEF   - default data width
//   NREGS_DEF  - default number of entries
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_mp.
// Ports:
//   init_busy - clear sweep in progress; forces the output to zero
//   raddr     - read address
//   mem_data  - stored entry at raddr, supplied by the top
//   we        - write enables of all NWR write ports
//   waddr     - packed write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata     - packed write data, port k at [k*XLEN +: XLEN]
//   rdata     - resolved read data
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ADDR_W   = 5,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  init_busy,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic [XLEN-1:0]       mem_data,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*XLEN-1:0]   wdata,
    output logic [XLEN-1:0]       rdata
);

    // Sources are applied lowest priority first so each later override wins:
    // storage, then bypass (ascending port index, so the highest match wins),
    // then the zero entry, then the sweep.
    always_comb begin
        rdata = mem_data;
        if (BYPASS != 0) begin
            for (int unsigned k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr)) begin
                    rdata = wdata[k*XLEN +: XLEN];
                end
            end
        end
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata = '0;
        end
        if (init_busy) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file.
// After reset the storage is cleared one entry per cycle, so the array needs
// no reset of its own; writes are ignored and reads return 0 until done.
// Ports:
//   clk_i       - clock, all state updates on the rising edge
//   rst_i       - synchronous active-high reset, restarts the clear sweep
//   init_busy_o - high while the clear sweep runs
//   we_i        - per-port write enable (NWR bits)
//   waddr_i     - write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata_i     - write data, port k at [k*XLEN +: XLEN]
//   raddr_i     - read addresses, port j at [j*ADDR_W +: ADDR_W]
//   rdata_o     - combinational read data, port j at [j*XLEN +: XLEN]
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  init_busy_o,
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*ADDR_W-1:0] waddr_i,
    input  logic [NWR*XLEN-1:0]   wdata_i,
    input  logic [NRD*ADDR_W-1:0] raddr_i,
    output logic [NRD*XLEN-1:0]   rdata_o
);

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [XLEN-1:0]   mem [NREGS];

    // Sweep FSM, storage writes and the registered busy flag.
    // Write ports are visited in ascending order so the highest-index port
    // targeting an address carries the last non-blocking assignment and wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RF_INIT;
            clr_cnt     <= '0;
            init_busy_o <= 1'b1;
        end else begin
            case (state)
                RF_INIT: begin
                    mem[clr_cnt] <= '0;
                    clr_cnt      <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(NREGS - 1)) begin
                        state       <= RF_READY;
                        init_busy_o <= 1'b0;
                    end
                end
                RF_READY: begin
                    for (int unsigned k = 0; k < NWR; k++) begin
                        if (we_i[k] &&
                            !((ZERO_REG != 0) && (waddr_i[k*ADDR_W +: ADDR_W] == '0))) begin
                            mem[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*XLEN +: XLEN];
                        end
                    end
                end
            endcase
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        assign raddr = raddr_i[j*ADDR_W +: ADDR_W];

        regfile_rdport #(
            .XLEN     (XLEN),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .init_busy (init_busy_o),
            .raddr     (raddr),
            .mem_data  (mem[raddr]),
            .we        (we_i),
            .waddr     (waddr_i),
            .wdata     (wdata_i),
            .rdata     (rdata_o[j*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: dut0 is NWR=1/BYPASS=0, dut1 is NWR=2/BYPASS=1,
// both 32x32 with a hardwired zero entry and two read ports.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    logic        busy0, busy1;
    logic [0:0]  we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic [9:0]  raddr0;
    logic [63:0] rdata0;
    logic [1:0]  we1;
    logic [9:0]  waddr1;
    logic [63:0] wdata1;
    logic [9:0]  raddr1;
    logic [63:0] rdata1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .ZERO_REG(1), .BYPASS(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .init_busy_o(busy0),
        .we_i(we0), .waddr_i(waddr0), .wdata_i(wdata0),
        .raddr_i(raddr0), .rdata_o(rdata0)
    );

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .init_busy_o(busy1),
        .we_i(we1), .waddr_i(waddr1), .wdata_i(wdata1),
        .raddr_i(raddr1), .rdata_o(rdata1)
    );

    typedef struct {
        logic        d0_we;
        logic [4:0]  d0_wa;
        logic [31:0] d0_wd;
        logic [1:0]  d1_we;
        logic [4:0]  d1_wa0;
        logic [31:0] d1_wd0;
        logic [4:0]  d1_wa1;
        logic [31:0] d1_wd1;
        logic [4:0]  d0_ra0, d0_ra1, d1_ra0, d1_ra1;
        logic [31:0] e00, e01, e10, e11;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = '0; waddr0 = '0; wdata0 = '0; raddr0 = '0;
        we1 = '0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
    endtask

    // Edges until busy0 falls, starting from an already-counted offset.
    task automatic count_busy(input int start, output int c);
        c = start;
        while (busy0 === 1'b1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    initial begin
        int cyc;

        //                d0we  d0wa   d0wd           d1we   wa0    wd0           wa1    wd1           d0ra0  d0ra1  d1ra0  d1ra1  e00            e01            e10           e11
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  5'd5,  32'h0,         32'h0,         32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0,        32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 2'b01, 5'd0,  32'h12345678, 5'd0,  32'h0,        5'd0,  5'd5,  5'd0,  5'd0,  32'h0,         32'hDEADBEEF,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       5'd7,  5'd7,  5'd7,  5'd0,  32'h0,         32'h0,         32'h22,       32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd5,  5'd7,  5'd7,  32'h0,         32'hDEADBEEF,  32'h22,       32'h22};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd9,  32'h44,       5'd9,  32'h33,       5'd9,  5'd9,  5'd9,  5'd7,  32'h0,         32'h0,         32'h33,       32'h22};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd9,  5'd9,  5'd9,  32'h0,         32'h0,         32'h33,       32'h33};
        vecs[8]  = '{1'b1, 5'd12, 32'h77,       2'b11, 5'd10, 32'h55,       5'd11, 32'h66,       5'd12, 5'd5,  5'd10, 5'd11, 32'h0,         32'hDEADBEEF,  32'h55,       32'h66};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd12, 5'd12, 5'd11, 5'd10, 32'h77,        32'h77,        32'h66,       32'h55};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd7,  32'hAB,       5'd9,  32'hCD,       5'd3,  5'd3,  5'd7,  5'd9,  32'h0,         32'h0,         32'hAB,       32'hCD};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd12, 5'd7,  5'd9,  32'hDEADBEEF,  32'h77,        32'hAB,       32'hCD};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd3,  5'd3,  5'd3,  32'h0,         32'h0,         32'h0,        32'h0};

        idle_inputs();
        rst = 1'b1;

        // Reset held three cycles: busy and zero reads.
        repeat (3) begin @(posedge clk); #1; end
        raddr0 = {5'd5, 5'd3};
        raddr1 = {5'd5, 5'd3};
        @(negedge clk);
        chk("rst busy0", {31'b0, busy0}, 32'd1);
        chk("rst busy1", {31'b0, busy1}, 32'd1);
        chk("rst d0 rd0", rdata0[31:0], 32'h0);
        chk("rst d1 rd1", rdata1[63:32], 32'h0);

        // Sweep with a write injected at sweep cycle 2.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAA;
        we1 = 2'b01; waddr1 = {5'd0, 5'd3}; wdata1 = {32'h0, 32'hAA};
        raddr0 = {5'd3, 5'd3};
        raddr1 = {5'd3, 5'd3};
        @(negedge clk);
        chk("sweep d0 rd0", rdata0[31:0], 32'h0);
        chk("sweep d1 rd0 bypass", rdata1[31:0], 32'h0);
        chk("sweep busy1", {31'b0, busy1}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        count_busy(3, cyc);
        chk("sweep busy length", cyc, 32);
        chk("sweep busy1 done", {31'b0, busy1}, 32'd0);

        // Every entry reads zero after the sweep, both DUTs, both ports.
        for (int a = 0; a < 32; a++) begin
            raddr0 = {5'(31 - a), 5'(a)};
            raddr1 = {5'(a), 5'(31 - a)};
            #1;
            chk($sformatf("clear d0 x%0d", a), rdata0[31:0] | rdata0[63:32], 32'h0);
            chk($sformatf("clear d1 x%0d", a), rdata1[31:0] | rdata1[63:32], 32'h0);
        end

        // Table vectors: one cycle each, expectations queued at drive time.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            we0    = vecs[i].d0_we;
            waddr0 = vecs[i].d0_wa;
            wdata0 = vecs[i].d0_wd;
            we1    = vecs[i].d1_we;
            waddr1 = {vecs[i].d1_wa1, vecs[i].d1_wa0};
            wdata1 = {vecs[i].d1_wd1, vecs[i].d1_wd0};
            raddr0 = {vecs[i].d0_ra1, vecs[i].d0_ra0};
            raddr1 = {vecs[i].d1_ra1, vecs[i].d1_ra0};
            sb_q.push_back(vecs[i].e00);
            sb_q.push_back(vecs[i].e01);
            sb_q.push_back(vecs[i].e10);
            sb_q.push_back(vecs[i].e11);
            @(negedge clk);
            chk($sformatf("vec%0d d0 rd0", i), rdata0[31:0],  sb_q.pop_front());
            chk($sformatf("vec%0d d0 rd1", i), rdata0[63:32], sb_q.pop_front());
            chk($sformatf("vec%0d d1 rd0", i), rdata1[31:0],  sb_q.pop_front());
            chk($sformatf("vec%0d d1 rd1", i), rdata1[63:32], sb_q.pop_front());
        end
        @(posedge clk); #1;
        idle_inputs();

        // Reset reasserted for one cycle at sweep cycle 10.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("mid busy at 10", {31'b0, busy0}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid busy in rst", {31'b0, busy0}, 32'd1);
        rst = 1'b0;
        count_busy(0, cyc);
        chk("mid busy length", cyc, 32);
        raddr0 = {5'd12, 5'd5};
        raddr1 = {5'd9, 5'd7};
        @(negedge clk);
        chk("mid d0 x5 cleared", rdata0[31:0], 32'h0);
        chk("mid d0 x12 cleared", rdata0[63:32], 32'h0);
        chk("mid d1 x7 cleared", rdata1[31:0], 32'h0);
        chk("mid d1 x9 cleared", rdata1[63:32], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read core regfile.
- Configurable width, depth, read-port count and write-port count.
- Optional hardwired-zero entry and same-cycle write-to-read bypass.
- Sequential clear sweep after reset, so storage needs no wide reset fan-out; sits in the decode/writeback stage of the pipelined core.

Parameters:
- XLEN, 32, data width of each entry.
- NREGS, 32, number of entries (power of two, >=2); ADDR_W = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 1, number of write ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = read of an address written in the same cycle returns the write data.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- init_busy_o  out  1  high while the clear sweep runs; writes ignored, reads return 0.
- we_i  in  NWR  per-port write enable.
- waddr_i  in  NWR*ADDR_W  write addresses; port k at [k*ADDR_W +: ADDR_W].
- wdata_i  in  NWR*XLEN  write data; port k at [k*XLEN +: XLEN].
- raddr_i  in  NRD*ADDR_W  read addresses; port j at [j*ADDR_W +: ADDR_W].
- rdata_o  out  NRD*XLEN  read data, combinational; port j at [j*XLEN +: XLEN].

Behaviour:
- Reset: clock clk_i; reset rst_i is synchronous, active-high.
  - A rising edge with rst_i=1 sets state=INIT and clr_cnt=0; init_busy_o=1 from that edge onward.
  - While rst_i stays high, remain in INIT with clr_cnt=0 and clear nothing.
- Init sweep (FSM INIT -> READY):
  - Each edge in INIT with rst_i=0 writes mem[clr_cnt]=0 and increments clr_cnt.
  - On the edge that clears entry NREGS-1, go to READY with init_busy_o=0.
  - init_busy_o is therefore high for exactly NREGS cycles after rst_i falls.
  - rst_i reasserted mid-sweep restarts the sweep from clr_cnt=0.
- Writes, READY only:
  - At the rising edge, port k with we_i[k]=1 stores wdata into mem[waddr].
  - If ZERO_REG=1, writes to address 0 are discarded.
  - Several ports writing the same address: the highest-index port wins.
  - All writes are ignored in INIT.
- Reads, combinational, evaluated per port in this priority:
  1. init_busy_o=1 -> 0.
  2. ZERO_REG=1 and address 0 -> 0.
  3. BYPASS=1 and any enabled write port targets the same address this cycle -> wdata of the highest-index matching port.
  4. Otherwise mem[raddr].
- Read latency is 0 cycles. Write-to-read latency is 0 cycles with BYPASS=1, otherwise 1 cycle.
- Output reset values:
  - init_busy_o=1.
  - rdata_o=0 during reset and the sweep.
  - Entry 0 reads 0 forever when ZERO_REG=1.
- No X propagation: memory content is only observable after the sweep completes.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - typedef enum {RF_INIT, RF_READY} rf_state_e.
  - Default constants XLEN_DEF=32 and NREGS_DEF=32.
- One sub-module, regfile_rdport, per read port (instantiated NRD times in a generate loop):
  - Combinational.
  - Implements the zero/bypass/priority mux for one address against all NWR write ports.
- The sweep FSM and storage stay in regfile_mp.

Test Plan:
- Sweep: assert rst_i 3 cycles, release -> init_busy_o=1 for exactly 32 cycles; afterwards every address reads 0x00000000.
- Basic write/read, BYPASS=0: write 0xDEADBEEF to x5 -> same cycle rdata=old 0; next cycle raddr=5 reads 0xDEADBEEF on both read ports.
- Zero register: write 0x12345678 to x0 -> x0 reads 0 on both the same and the following cycle, for both BYPASS values.
- Bypass and multi-write (NWR=2, BYPASS=1):
  - Port0 writes 0x11 and port1 writes 0x22 to x7 in the same cycle -> same-cycle read of x7 = 0x22; next cycle = 0x22.
  - Port1 alone writing x9=0x33 -> same-cycle read of x9 = 0x33.
- Write during sweep: we_i=1 to x3 with 0xAA at sweep cycle 2 -> ignored; after the sweep x3 reads 0; reads during the sweep return 0.
- Reset mid-sweep: reassert rst_i at sweep cycle 10 for 1 cycle -> init_busy_o stays high and falls exactly 32 cycles after the second release.
